// File: rtl/aes_pkg.sv
// Shared constants for the 16-bit nibble key schedule: widths, FSM encoding and the
// NibbleSub substitution table.
package aes_pkg;

  localparam int KW = 16;  // key width, four nibbles {w0,w1,w2,w3}
  localparam int RW = 4;   // round index / round constant width
  localparam int NW = 4;   // nibble width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EMIT = 3'd1,
    ST_SUB  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [NW-1:0] SBOX [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

endpackage

// File: rtl/nibble_sub.sv
// Registered 4-bit substitution box: b and valid appear the cycle after en.
module nibble_sub
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          en,
  input  logic [NW-1:0] a,
  output logic [NW-1:0] b,
  output logic          valid
);

  // NOTE: pure datapath flops carry no reset; the consumer only looks at them after
  // it has pulsed en itself, so their power-up contents are never observed.
  always_ff @(posedge clk) begin
    valid <= en;
    if (en) b <= SBOX[a];
  end

endmodule

// File: rtl/key_reverse_schedule.sv
// Walks the nibble key schedule backwards from round N to round 0, offering one round
// key at a time over a valid/ready handshake and time-sharing a single registered S-box.
module key_reverse_schedule
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [KW-1:0] last_key,
  input  logic [RW-1:0] num_rounds,
  output logic [KW-1:0] key_out,
  output logic [RW-1:0] round_idx,
  output logic          key_valid,
  input  logic          key_ready,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nx;
  logic [KW-1:0] cur;
  logic [RW-1:0] r;
  logic          load_start, load_prev;

  logic          sbox_en, sbox_valid;
  logic [NW-1:0] sbox_a, sbox_b;
  logic [NW-1:0] k0, k1, k2, k3;

  // Inverse step: the low three words undo the forward XOR chain, w0 needs S(k3).
  assign k3     = cur[3:0]   ^ cur[7:4];
  assign k2     = cur[7:4]   ^ cur[11:8];
  assign k1     = cur[11:8]  ^ cur[15:12];
  assign k0     = cur[15:12] ^ sbox_b ^ r;
  assign sbox_a = k3;

  nibble_sub u_sbox (
    .clk   (clk),
    .en    (sbox_en),
    .a     (sbox_a),
    .b     (sbox_b),
    .valid (sbox_valid)
  );

  // NOTE: every register is updated with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    key_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    sbox_en    = 1'b0;
    load_start = 1'b0;
    load_prev  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load_start = 1'b1;
          state_nx   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        key_valid = 1'b1;
        // Round 0 is checked before any decrement, so r never wraps.
        if (key_ready) state_nx = (r == '0) ? ST_DONE : ST_SUB;
      end
      ST_SUB: begin
        sbox_en  = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (sbox_valid) begin
          load_prev = 1'b1;
          state_nx  = ST_EMIT;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur <= '0;
      r   <= '0;
    end else if (load_start) begin
      cur <= last_key;
      r   <= num_rounds;
    end else if (load_prev) begin
      cur <= {k0, k1, k2, k3};
      r   <= r - 1'b1;
    end
  end

  // cur/r only change on start or when the next key is loaded, so they hold outside EMIT.
  assign key_out   = cur;
  assign round_idx = r;

endmodule
